// File: rtl/tpu_pkg.sv
// ============================================================================
//  Module   : tpu_pkg
//  Purpose  : Shared types and constants for the NxN matrix-multiply engine:
//             FSM state encoding, default dimension/element width and the
//             accumulator width derivation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package tpu_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  localparam int c_def_n  = 2;
  localparam int c_def_dw = 8;

  // A sum of n products of two signed dw-bit values needs 2*dw bits per
  // product plus log2(n) bits of growth to never wrap.
  function automatic int calc_aw(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_pe.sv
// ============================================================================
//  Module   : mac_pe
//  Purpose  : Signed multiply-accumulate cell. acc <= acc + a*b when en,
//             synchronous zero when clr (clr wins over en).
//  Ports    : clk, rst_n (async active-low), clr, en,
//             a/b [DW-1:0] signed operands, acc [AW-1:0] signed accumulator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_pe #(
  parameter int DW = 8,
  parameter int AW = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [AW-1:0]   r_acc;

  // Operands are widened first so the product is formed at full precision.
  assign w_prod = (2*DW)'(a) * (2*DW)'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + AW'(w_prod);
    end
  end

  assign acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/matmul_engine_nxn.sv
// ============================================================================
//  Module   : matmul_engine_nxn
//  Purpose  : Computes C = A x W for signed NxN matrices. Loads W then A as a
//             row-major stream, runs N compute cycles over an NxN grid of
//             mac_pe cells, then drains C row-major over a valid/ready port.
//  Ports    : clk, rst_n (async active-low), clear (sync abort), keep_w,
//             in_valid/in_ready/in_data[DW-1:0]   load stream,
//             out_valid/out_ready/out_data[AW-1:0]/out_last  result stream,
//             busy (COMPUTE or DRAIN).
//  Options  : MATMUL_SAT_EN - clamp each result to the DW-bit signed range
//             before sign-extending onto out_data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matmul_engine_nxn
  import tpu_pkg::*;
#(
  parameter int N  = c_def_n,
  parameter int DW = c_def_dw,
  parameter int AW = calc_aw(DW, N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          keep_w,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int c_nn   = N * N;
  localparam int c_ld_w = $clog2(2 * c_nn);
  localparam int c_k_w  = $clog2(N);
  localparam int c_dr_w = $clog2(c_nn);

  state_t            r_state, w_state_nxt;
  logic [c_ld_w-1:0] r_ld_cnt, w_ld_nxt;
  logic [c_k_w-1:0]  r_k, w_k_nxt;
  logic [c_dr_w-1:0] r_dr_cnt, w_dr_nxt;

  // Operand storage is intentionally not reset: it is always fully written
  // before being consumed (W may be reused across operations).
  logic signed [DW-1:0] r_w [c_nn];
  logic signed [DW-1:0] r_a [c_nn];

  logic signed [AW-1:0] w_acc [c_nn];
  logic signed [AW-1:0] w_sel;
  logic signed [AW-1:0] w_res;
  logic                 w_ld_fire;
  logic                 w_pe_clr;
  logic                 w_pe_en;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_LOAD;
      r_ld_cnt <= '0;
      r_k      <= '0;
      r_dr_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ld_cnt <= w_ld_nxt;
      r_k      <= w_k_nxt;
      r_dr_cnt <= w_dr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_nxt    = r_ld_cnt;
    w_k_nxt     = r_k;
    w_dr_nxt    = r_dr_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    case (r_state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_ld_cnt == c_ld_w'(2 * c_nn - 1)) begin
            w_ld_nxt    = '0;
            w_k_nxt     = '0;
            w_state_nxt = ST_COMPUTE;
          end else begin
            w_ld_nxt = r_ld_cnt + 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (r_k == c_k_w'(N - 1)) begin
          w_k_nxt     = '0;
          w_dr_nxt    = '0;
          w_state_nxt = ST_DRAIN;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (r_dr_cnt == c_dr_w'(c_nn - 1)) begin
            w_dr_nxt    = '0;
            // Reusing W skips straight to the A half of the load stream.
            w_ld_nxt    = keep_w ? c_ld_w'(c_nn) : '0;
            w_state_nxt = ST_LOAD;
          end else begin
            w_dr_nxt = r_dr_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase

    // Abort overrides every transition computed above.
    if (clear) begin
      w_state_nxt = ST_LOAD;
      w_ld_nxt    = '0;
      w_k_nxt     = '0;
      w_dr_nxt    = '0;
    end
  end

  // ------------------------------------------------------------ storage ----
  assign w_ld_fire = in_valid && (r_state == ST_LOAD) && !clear;

  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      for (int e = 0; e < c_nn; e++) begin
        if (r_ld_cnt == c_ld_w'(e))        r_w[e] <= in_data;
        if (r_ld_cnt == c_ld_w'(e + c_nn)) r_a[e] <= in_data;
      end
    end
  end

  // ---------------------------------------------------------- PE array ----
  // Holding the accumulators at zero throughout LOAD guarantees they start
  // from zero on COMPUTE entry regardless of how LOAD was reached.
  assign w_pe_clr = (r_state == ST_LOAD);
  assign w_pe_en  = (r_state == ST_COMPUTE);

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DW-1:0] w_a_op;
      logic signed [DW-1:0] w_b_op;

      // Step k feeds A[i][k] and W[k][j] into cell (i,j).
      always_comb begin
        w_a_op = '0;
        w_b_op = '0;
        for (int kk = 0; kk < N; kk++) begin
          if (r_k == c_k_w'(kk)) begin
            w_a_op = r_a[i*N + kk];
            w_b_op = r_w[kk*N + j];
          end
        end
      end

      mac_pe #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_pe_clr),
        .en    (w_pe_en),
        .a     (w_a_op),
        .b     (w_b_op),
        .acc   (w_acc[i*N + j])
      );
    end
  end

  // -------------------------------------------------------------- drain ----
  always_comb begin
    w_sel = '0;
    for (int e = 0; e < c_nn; e++) begin
      if (r_dr_cnt == c_dr_w'(e)) w_sel = w_acc[e];
    end
  end

`ifdef MATMUL_SAT_EN
  localparam logic signed [AW-1:0] c_sat_max = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] c_sat_min = AW'(-(2 ** (DW - 1)));

  always_comb begin
    if (w_sel > c_sat_max)      w_res = c_sat_max;
    else if (w_sel < c_sat_min) w_res = c_sat_min;
    else                        w_res = w_sel;
  end
`else
  assign w_res = w_sel;
`endif

  assign out_data = out_valid ? w_res : '0;
  assign out_last = out_valid && (r_dr_cnt == c_dr_w'(c_nn - 1));

endmodule

`default_nettype wire

// File: tb/tb_matmul_engine_nxn.sv
// ============================================================================
//  Module   : tb_matmul_engine_nxn
//  Purpose  : Self-checking bench for matmul_engine_nxn (N=2, DW=8): directed
//             and random operations compared against a plain-arithmetic
//             matrix product model, plus reset/clear abort scenarios.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_matmul_engine_nxn;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 17;
  localparam int NN = N * N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          keep_w = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [AW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic signed [DW-1:0] tw [NN];
  logic signed [DW-1:0] ta [NN];
  logic [AW-1:0]        expq [NN];

  always #5 clk = ~clk;

  matmul_engine_nxn #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .keep_w    (keep_w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // C[i][j] = sum_k A[i][k]*W[k][j], optionally clamped to the DW-bit range.
  task automatic build_exp();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < N; k++) begin
          int av;
          int wv;
          av = ta[i*N + k];
          wv = tw[k*N + j];
          s += av * wv;
        end
`ifdef MATMUL_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        expq[i*N + j] = AW'(s);
      end
    end
  endtask

  task automatic randomize_mats();
    for (int e = 0; e < NN; e++) begin
      tw[e] = DW'($urandom);
      ta[e] = DW'($urandom);
    end
  endtask

  task automatic do_load(input bit with_w, input bit clr_last);
    int first;
    first = with_w ? 0 : NN;
    for (int b = first; b < 2 * NN; b++) begin
      in_valid = 1'b1;
      in_data  = (b < NN) ? tw[b] : ta[b - NN];
      if (clr_last && b == 2 * NN - 1) clear = 1'b1;
      chk("load_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clear    = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_first(input bit junk);
    int edges;
    edges = 0;
    while (!out_valid && edges < 20) begin
      chk("busy_compute", busy, 1);
      if (junk) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("first_latency", edges + 1, N + 1);
  endtask

  task automatic drain(input int mode, input bit kw, input bit junk);
    int idx;
    int cyc;
    bit rdy;
    idx = 0;
    cyc = 0;
    keep_w = kw;
    while (idx < NN && cyc < 60) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (junk) begin
        in_valid = 1'b1;
        in_data  = DW'($urandom);
      end
      chk("drain_valid", out_valid, 1);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_data", out_data, expq[idx]);
      chk("drain_last", out_last, idx == NN - 1);
      if (rdy) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    keep_w    = 1'b0;
    chk("drain_count", idx, NN);
    chk("post_in_ready", in_ready, 1);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    bit prev_kw;
    bit kw;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed product, free-flowing output
    tw[0] = 8'sd5; tw[1] = 8'sd6; tw[2] = 8'sd7; tw[3] = 8'sd8;
    ta[0] = 8'sd1; ta[1] = 8'sd2; ta[2] = 8'sd3; ta[3] = 8'sd4;
    build_exp();
    chk("model_c00", expq[0], 19);
    chk("model_c11", expq[3], 50);
    do_load(1'b1, 1'b0);
    wait_first(1'b0);
    drain(0, 1'b0, 1'b0);

    // Same product with out_ready 1,0,0,1 and weight reuse requested
    do_load(1'b1, 1'b0);
    wait_first(1'b0);
    drain(1, 1'b1, 1'b0);

    // Only A reloaded (identity) -> W comes back out
    ta[0] = 8'sd1; ta[1] = 8'sd0; ta[2] = 8'sd0; ta[3] = 8'sd1;
    build_exp();
    do_load(1'b0, 1'b0);
    wait_first(1'b0);
    drain(0, 1'b0, 1'b0);

    // Largest magnitude corner: all elements -128
    for (int e = 0; e < NN; e++) begin
      tw[e] = -8'sd128;
      ta[e] = -8'sd128;
    end
    build_exp();
    do_load(1'b1, 1'b0);
    wait_first(1'b0);
    drain(0, 1'b0, 1'b0);

    // Random operations, random backpressure, junk input while busy
    prev_kw = 1'b0;
    for (int it = 0; it < 8; it++) begin
      if (prev_kw) begin
        for (int e = 0; e < NN; e++) ta[e] = DW'($urandom);
      end else begin
        randomize_mats();
      end
      build_exp();
      kw = 1'($urandom_range(0, 1));
      do_load(!prev_kw, 1'b0);
      wait_first(1'b1);
      drain(2, kw, 1'b1);
      prev_kw = kw;
    end

    // Reset pulsed during compute cycle 1 discards the operation
    randomize_mats();
    do_load(1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_valid", seen, 0);
    chk("rst_after_in_ready", in_ready, 1);

    // Clear together with the final A beat blocks COMPUTE entry
    randomize_mats();
    do_load(1'b1, 1'b1);
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("clr_no_compute", seen, 0);

    // Load counter restarted from zero: a full load must work
    randomize_mats();
    build_exp();
    do_load(1'b1, 1'b0);
    wait_first(1'b0);
    drain(2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matmul_engine_nxn.md
MATMUL_ENGINE_NXN -- requirements
Module: matmul_engine_nxn

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning matrix dimension; legal range 2..4.
REQ-002 The block SHALL have parameter DW, default 8, meaning element width in bits; elements are signed two's complement.
REQ-003 The block SHALL have parameter AW, default 2*DW+$clog2(N), meaning accumulator and result width.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 clear  in  1  synchronous abort; returns to LOAD with counters zeroed, memories kept.
REQ-007 keep_w  in  1  weight-reuse request, sampled on the DRAIN-to-LOAD transition.
REQ-008 in_valid  in  1  load beat valid.
REQ-009 in_ready  out  1  load beat accepted when in_valid&in_ready.
REQ-010 in_data  in  DW  load element.
REQ-011 out_valid  out  1  result beat valid.
REQ-012 out_ready  in  1  consumer accepts result.
REQ-013 out_data  out  AW  result element, sign-extended.
REQ-014 out_last  out  1  high with the final (N*N-th) result beat.
REQ-015 busy  out  1  high in COMPUTE or DRAIN.

Function
REQ-016 FSM states SHALL be LOAD, COMPUTE, DRAIN; in_ready=1 only in LOAD, out_valid=1 only in DRAIN.
REQ-017 LOAD SHALL accept 2*N*N beats: beats 0..N*N-1 fill W row-major, beats N*N..2*N*N-1 fill A row-major.
REQ-018 On the cycle the final A beat is accepted, the FSM SHALL enter COMPUTE on the next edge.
REQ-019 COMPUTE SHALL last exactly N cycles; in cycle k each of N*N accumulators adds A[i][k]*W[k][j], giving C[i][j]=sum_k A[i][k]*W[k][j].
REQ-020 Accumulators SHALL be zeroed on COMPUTE entry; arithmetic is signed, full precision in AW bits, never wrapping for legal N.
REQ-021 DRAIN SHALL present C row-major, one element per out_valid&out_ready handshake; out_data/out_last held stable while out_valid&!out_ready.
REQ-022 out_valid SHALL first assert the cycle after COMPUTE ends (load-complete to first result = N+1 cycles).
REQ-023 After the out_last handshake the FSM SHALL enter LOAD; if keep_w=1 then, the load counter starts at N*N (W retained, only A reloaded), else at 0.
REQ-024 in_valid outside LOAD SHALL be ignored; no state change.
REQ-025 clear SHALL take priority over every transition, including a simultaneous final load beat or last-result handshake.
REQ-026 W and A storage SHALL NOT be cleared by clear or reset; contents are undefined after reset.

Reset
REQ-027 While rst_n=0: state=LOAD, load counter=0, drain counter=0, accumulators=0, in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-028 Reset asserted mid-COMPUTE or mid-DRAIN SHALL discard the operation; no further out_valid until a full load completes.

Configuration
REQ-029 With MATMUL_SAT_EN defined, each result SHALL be clamped to [-2^(DW-1), 2^(DW-1)-1] then sign-extended to AW on out_data.
REQ-030 Without MATMUL_SAT_EN, out_data SHALL carry the full AW-bit accumulator unmodified.

Structure
REQ-031 Package tpu_pkg SHALL hold the FSM state enum and default N/DW constants plus the AW derivation function.
REQ-032 Each accumulator SHALL be an instance of sub-module mac_pe (signed DW x DW multiply, AW accumulate, synchronous zero).

Verification (N=2, DW=8)
REQ-033 W=[[5,6],[7,8]], A=[[1,2],[3,4]], out_ready=1 -> results 19,22,43,50, out_last on 50, first out_valid 3 cycles after last load beat.
REQ-034 All elements -128, MATMUL_SAT_EN undefined -> four results 32768 (AW=17); with MATMUL_SAT_EN -> four results 127.
REQ-035 Repeat REQ-033 with out_ready toggling 1,0,0,1 -> same sequence, data stable during stalls, no beat dropped or duplicated.
REQ-036 keep_w=1 at end of REQ-033, then load only A=[[1,0],[0,1]] -> results 5,6,7,8.
REQ-037 rst_n pulsed low in COMPUTE cycle 1 -> out_valid stays 0, in_ready=1 next cycle; clear asserted on final A beat -> state LOAD, no COMPUTE entry.
